// File: rtl/sysid_check_pkg.sv
// Shared types for the system-ID check master.
// FSM states, Avalon word addresses and err_flags bit positions.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int ERR_ID = 0;
  localparam int ERR_TS = 1;
  localparam int ERR_TO = 2;

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the sysid slave.
// The master owns address/read; the slave owns readdata/waitrequest.
interface sysid_check_master_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/sysid_check_master.sv
// Reads the sysid ID and timestamp words and compares them to parameters.
// Define SYSID_CHECK_TIMEOUT_EN to add a per-read stall timeout.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sysid_check_master_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  output logic [2:0]           err_flags
);

  state_t state;
  state_t state_nx;

  logic rd_ok;
  logic rd_to;
  logic err_id;
  logic err_ts;
  logic err_to;

  assign rd_ok = avm.avm_read && !avm.avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic [15:0] stall_cnt;

  // Idle read strobe marks entry to a read state, so the count restarts.
  always_ff @(posedge clock) begin
    if (reset || !avm.avm_read) begin
      stall_cnt <= '0;
    end else if (avm.avm_waitrequest) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign rd_to = avm.avm_read
              && avm.avm_waitrequest
              && (stall_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      err_to <= 1'b0;
    end else if (state == IDLE && start) begin
      err_to <= 1'b0;
    end else if (rd_to) begin
      err_to <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign rd_to  = 1'b0;
  assign err_to = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RD_ID;
      end
      RD_ID: begin
        if (rd_to)      state_nx = FIN;
        else if (rd_ok) state_nx = RD_TS;
      end
      RD_TS: begin
        if (rd_to)      state_nx = FIN;
        else if (rd_ok) state_nx = CHECK;
      end
      CHECK:   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read strobe is registered: each read state opens with one idle cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm.avm_read    <= 1'b0;
      avm.avm_address <= ADDR_ID;
      pass            <= 1'b0;
      err_id          <= 1'b0;
      err_ts          <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pass     <= 1'b0;
            err_id   <= 1'b0;
            err_ts   <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
          end
        end
        RD_ID: begin
          if (rd_to) begin
            avm.avm_read <= 1'b0;
          end else if (rd_ok) begin
            id_value     <= avm.avm_readdata;
            avm.avm_read <= 1'b0;
          end else if (!avm.avm_read) begin
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_ID;
          end
        end
        RD_TS: begin
          if (rd_to) begin
            avm.avm_read <= 1'b0;
          end else if (rd_ok) begin
            ts_value     <= avm.avm_readdata;
            avm.avm_read <= 1'b0;
          end else if (!avm.avm_read) begin
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_TS;
          end
        end
        CHECK: begin
          err_id <= (id_value != EXPECTED_ID);
          err_ts <= (ts_value != EXPECTED_TS);
          pass   <= (id_value == EXPECTED_ID)
                 && (ts_value == EXPECTED_TS)
                 && !err_to;
        end
        FIN: ;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_comb begin
    err_flags         = '0;
    err_flags[ERR_ID] = err_id;
    err_flags[ERR_TS] = err_ts;
    err_flags[ERR_TO] = err_to;
  end

endmodule

// File: doc/sysid_check_master.md
SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0, the system ID value the design must match.
REQ-002 Parameter EXPECTED_TS, default 32'd0, the build timestamp the design must match.
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd1024, the maximum number of cycles one read may stall.
REQ-004 clock  input  1  system clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a check sequence.
REQ-007 avm_address  output  1  Avalon-MM word address: 0 = ID, 1 = timestamp.
REQ-008 avm_read  output  1  Avalon-MM read request.
REQ-009 avm_readdata  input  32  Avalon-MM read data, valid in the cycle that avm_read=1 and avm_waitrequest=0.
REQ-010 avm_waitrequest  input  1  slave stall.
REQ-011 busy  output  1  high while a sequence is in progress.
REQ-012 done  output  1  one-cycle pulse when a sequence completes.
REQ-013 pass  output  1  sticky result: both values matched and no timeout occurred.
REQ-014 id_value  output  32  captured ID word.
REQ-015 ts_value  output  32  captured timestamp word.
REQ-016 err_flags  output  3  sticky error bits: {timeout, ts_mismatch, id_mismatch}.

Function
REQ-017 The FSM SHALL use the states IDLE, RD_ID, RD_TS, CHECK and FIN.
REQ-018 In IDLE, a start pulse SHALL clear pass, err_flags, id_value and ts_value, then move to RD_ID on the next cycle.
REQ-019 In RD_ID, the block SHALL drive avm_read=1 and avm_address=0, holding both stable until a cycle with avm_waitrequest=0.
REQ-020 On acceptance in RD_ID, the block SHALL capture avm_readdata into id_value and move to RD_TS, with avm_read deasserted for at least one cycle between the two reads.
REQ-021 In RD_TS, the block SHALL behave as in RD_ID but with avm_address=1 and capture into ts_value, then move to CHECK.
REQ-022 In CHECK, lasting one cycle, the block SHALL set id_mismatch = (id_value != EXPECTED_ID), set ts_mismatch = (ts_value != EXPECTED_TS), and set pass = no error bit set.
REQ-023 In FIN, the block SHALL pulse done for exactly one cycle and then return to IDLE.
REQ-024 With zero wait states, the latency from the start pulse to done SHALL be 6 cycles.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A start pulse received while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 avm_address SHALL NOT change while avm_read=1 and avm_waitrequest=1.
REQ-028 The block SHALL capture data only on a cycle where avm_read=1 and avm_waitrequest=0.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE and avm_read, avm_address, busy, done, pass, err_flags, id_value and ts_value SHALL all be 0.
REQ-030 Reset asserted mid-read SHALL deassert avm_read on the next edge and abandon the sequence without a done pulse.

Configuration
REQ-031 With SYSID_CHECK_TIMEOUT_EN defined, a 16-bit stall counter SHALL be cleared on entry to each read state and increment each cycle that waitrequest=1.
REQ-032 With SYSID_CHECK_TIMEOUT_EN defined, when the stall counter reaches TIMEOUT_CYCLES the block SHALL set timeout, drop avm_read, skip to FIN and leave pass=0.
REQ-033 Without SYSID_CHECK_TIMEOUT_EN, the block SHALL contain no counter, SHALL wait indefinitely, and err_flags[2] SHALL be constant 0.

Structure
REQ-034 A package sysid_check_pkg SHALL hold the state enum, the address constants ADDR_ID=1'b0 and ADDR_TS=1'b1, and the err_flags bit indices.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline logic.

Verification
REQ-036 EXPECTED_ID=1513181670, EXPECTED_TS=0, zero-wait slave returning those values, start -> done at cycle 6, pass=1, err_flags=3'b000.
REQ-037 Slave returns ID 32'h0000_0001 -> done, pass=0, err_flags=3'b001, id_value=1.
REQ-038 Slave holds waitrequest=1 for 5 cycles on each read -> address stable throughout, done at cycle 16, pass=1.
REQ-039 With SYSID_CHECK_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and waitrequest held at 1 -> avm_read drops after 8 stall cycles, done pulses, err_flags=3'b100, pass=0.
REQ-040 start pulsed during RD_TS, plus reset asserted during RD_ID on a second run -> no second sequence runs; after reset all outputs are 0 with no done pulse.
